ahb_apb_bridge_ctrl: RTL and testbench

AHB_APB_BRIDGE_CTRL -- requirements
Module: ahb_apb_bridge_ctrl

---
 rtl/ahb_apb_bridge_ctrl.sv | 115 +++++++++++
 tb/tb_ahb_apb_bridge_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave to APB master bridge controller: one AHB transfer at a time
// is turned into an APB SETUP/ACCESS pair, with a two-cycle AHB error response.
module ahb_apb_bridge_ctrl #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WDATA  = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_ACCESS = 3'd3;
   localparam logic [2:0] ST_ERR1   = 3'd4;
   localparam logic [2:0] ST_ERR2   = 3'd5;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       accept;

   function automatic logic [3:0] write_strobe(input logic [2:0] size,
                                               input logic [1:0] offset);
      logic [3:0] strb;
      case (size)
         3'd0:    strb = 4'b0001 << offset;
         3'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   // New transfers are only taken while the bridge is showing HREADYOUT=1
   assign accept = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) &&
                   (state == ST_IDLE || state == ST_ERR2);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ERR2: begin
            if (accept)
               state_nxt = HWRITE ? ST_WDATA : ST_SETUP;
            else
               state_nxt = ST_IDLE;
         end
         ST_WDATA:  state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY)
               state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
         end
         ST_ERR1:   state_nxt = ST_ERR2;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs are decoded from the next state so they are registered
   // yet still line up with the state they describe.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
      end else begin
         state     <= state_nxt;
         HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
         HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
         PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
         PENABLE   <= (state_nxt == ST_ACCESS);
      end
   end

   // Address, direction and strobes change only on acceptance, so they stay
   // stable for the whole APB transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PSTRB  <= 4'b0000;
         PWDATA <= 32'h0;
         HRDATA <= 32'h0;
      end else begin
         if (accept) begin
            PADDR  <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
            PWRITE <= HWRITE;
            PSTRB  <= HWRITE ? write_strobe(HSIZE, HADDR[1:0]) : 4'b0000;
         end
         if (state == ST_WDATA)
            PWDATA <= HWDATA;
         if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE)
            HRDATA <= PRDATA;
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Scoreboard bench for ahb_apb_bridge_ctrl: an AHB master task, an APB slave
// model with programmable wait states/errors, and monitors on both sides.
module tb_ahb_apb_bridge_ctrl;
   localparam int AW = 16;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic          HWRITE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic [AW-1:0] PADDR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [31:0]   PWDATA;
   logic [3:0]    PSTRB;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   ahb_apb_bridge_ctrl #(.ADDR_WIDTH(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   bit blockReady = 1'b0;
   assign HREADY = HREADYOUT && !blockReady;

   // APB slave model: wait count loaded in SETUP, counts down in ACCESS
   logic [31:0] slvRdata = 32'h0;
   bit          slvErr = 1'b0;
   int          slvWaits = 0;
   int          waitCnt;
   assign PREADY  = PSEL && PENABLE && (waitCnt == 0);
   assign PRDATA  = slvRdata;
   assign PSLVERR = slvErr && PREADY;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         waitCnt <= 0;
      else if (PSEL && !PENABLE)
         waitCnt <= slvWaits;
      else if (PSEL && PENABLE && waitCnt > 0)
         waitCnt <= waitCnt - 1;
   end

   typedef struct {
      bit          err;
      logic [31:0] rdata;
      int          waits;
      int          psel;
   } ahb_exp_t;

   typedef struct {
      logic [AW-1:0] paddr;
      bit            pwrite;
      logic [3:0]    pstrb;
      logic [31:0]   pwdata;
   } apb_exp_t;

   ahb_exp_t    ahbQ[$];
   apb_exp_t    apbQ[$];
   ahb_exp_t    ahbE;
   apb_exp_t    apbE;
   logic [31:0] modelHrdata = 32'h0;
   int          errors = 0;
   int          checks = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Monitors: acceptance seen at the active edge, everything else mid-cycle
   bit            phase = 1'b0;
   int            waitSeen, pselSeen, errLowSeen;
   int            cyc = 0, acceptCyc = 0, doneCyc = 0;
   logic [AW-1:0] snapAddr;
   logic          snapWrite;
   logic [3:0]    snapStrb;
   logic [31:0]   snapWdata;

   always @(posedge HCLK) begin
      if (HRESETn && HSEL && HREADY && HTRANS[1] && HREADYOUT) begin
         phase      = 1'b1;
         waitSeen   = 0;
         pselSeen   = 0;
         errLowSeen = 0;
         acceptCyc  = cyc;
      end
      cyc++;
   end

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         phase = 1'b0;
      end else begin
         if (PSEL && !PENABLE) begin
            if (apbQ.size() == 0) begin
               checkOutput("apb_unexpected_setup", 1, 0);
            end else begin
               apbE = apbQ.pop_front();
               checkOutput("paddr", PADDR, apbE.paddr);
               checkOutput("pwrite", PWRITE, apbE.pwrite);
               checkOutput("pstrb", PSTRB, apbE.pstrb);
               if (apbE.pwrite)
                  checkOutput("pwdata", PWDATA, apbE.pwdata);
            end
            snapAddr  = PADDR;
            snapWrite = PWRITE;
            snapStrb  = PSTRB;
            snapWdata = PWDATA;
         end else if (PSEL && PENABLE) begin
            checkOutput("apb_stable", {PADDR, PWRITE, PSTRB, PWDATA},
                        {snapAddr, snapWrite, snapStrb, snapWdata});
         end
         if (phase) begin
            if (PSEL)
               pselSeen++;
            if (!HREADYOUT) begin
               waitSeen++;
               if (HRESP)
                  errLowSeen++;
            end else begin
               phase   = 1'b0;
               doneCyc = cyc;
               if (ahbQ.size() == 0) begin
                  checkOutput("ahb_unexpected_done", 1, 0);
               end else begin
                  ahbE = ahbQ.pop_front();
                  checkOutput("hresp", HRESP, ahbE.err);
                  checkOutput("hrdata", HRDATA, ahbE.rdata);
                  checkOutput("wait_states", waitSeen, ahbE.waits);
                  checkOutput("psel_cycles", pselSeen, ahbE.psel);
                  checkOutput("err1_cycles", errLowSeen, ahbE.err ? 1 : 0);
               end
            end
         end
      end
   end

   task automatic driveAddr(input bit wr, input logic [AW-1:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits,
                            input bit err);
      ahb_exp_t   a;
      apb_exp_t   p;
      logic [3:0] strb;
      if (!wr)
         strb = 4'b0000;
      else if (size == 3'd0)
         strb = 4'b0001 << addr[1:0];
      else if (size == 3'd1)
         strb = addr[1] ? 4'b1100 : 4'b0011;
      else
         strb = 4'b1111;
      p.paddr  = {addr[AW-1:2], 2'b00};
      p.pwrite = wr;
      p.pstrb  = strb;
      p.pwdata = wdata;
      apbQ.push_back(p);
      if (!wr && !err)
         modelHrdata = rdata;
      a.err   = err;
      a.rdata = modelHrdata;
      a.waits = (wr ? 3 : 2) + waits + (err ? 1 : 0);
      a.psel  = 2 + waits;
      ahbQ.push_back(a);
      slvWaits = waits;
      slvRdata = rdata;
      slvErr   = err;
      HSEL     = 1'b1;
      HTRANS   = 2'b10;
      HADDR    = addr;
      HWRITE   = wr;
      HSIZE    = size;
      HWDATA   = ~wdata;
   endtask

   task automatic waitDone();
      int n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!HREADYOUT && n < 40);
      if (!HREADYOUT)
         checkOutput("done_timeout", 0, 1);
      #1;
   endtask

   task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits,
                                input bit err);
      driveAddr(wr, addr, size, wdata, rdata, waits, err);
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWDATA = wdata;
      waitDone();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   initial begin
      int          firstDone;
      int          n;
      bit          wr;
      logic [2:0]  sz;
      HRESETn = 1'b1;
      HSEL    = 1'b0;
      HADDR   = '0;
      HTRANS  = 2'b00;
      HSIZE   = 3'd0;
      HWRITE  = 1'b0;
      HWDATA  = 32'h0;
      #2 HRESETn = 1'b0;
      #1;
      checkOutput("rst_hreadyout", HREADYOUT, 1);
      checkOutput("rst_hresp", HRESP, 0);
      checkOutput("rst_hrdata", HRDATA, 0);
      checkOutput("rst_psel", PSEL, 0);
      checkOutput("rst_penable", PENABLE, 0);
      checkOutput("rst_pwrite", PWRITE, 0);
      checkOutput("rst_paddr", PADDR, 0);
      checkOutput("rst_pwdata", PWDATA, 0);
      checkOutput("rst_pstrb", PSTRB, 0);
      repeat (2) @(negedge HCLK);
      #2 HRESETn = 1'b1;
      idleCycles(1);

      applyStimulus(1'b0, 16'h0124, 3'd2, 32'h0, 32'hCAFE0001, 0, 1'b0);
      idleCycles(1);
      applyStimulus(1'b1, 16'h0012, 3'd0, 32'h00AB0000, 32'h0, 3, 1'b0);
      idleCycles(1);
      applyStimulus(1'b1, 16'h0016, 3'd1, 32'h5A5A0000, 32'h0, 0, 1'b0);
      applyStimulus(1'b1, 16'h0021, 3'd2, 32'h01020304, 32'h0, 1, 1'b0);
      applyStimulus(1'b1, 16'h0033, 3'd3, 32'hFFEE0011, 32'h0, 0, 1'b0);
      applyStimulus(1'b1, 16'h0007, 3'd0, 32'h77000000, 32'h0, 0, 1'b0);

      // Slave error on a read: HRDATA must keep the last good read data
      idleCycles(1);
      applyStimulus(1'b0, 16'h0200, 3'd2, 32'h0, 32'hDEADBEEF, 0, 1'b1);
      @(negedge HCLK);
      checkOutput("post_err_hresp", HRESP, 0);
      checkOutput("post_err_hreadyout", HREADYOUT, 1);
      checkOutput("post_err_hrdata", HRDATA, 32'hCAFE0001);
      #1;

      applyStimulus(1'b1, 16'h0040, 3'd2, 32'hA5A5A5A5, 32'h0, 0, 1'b0);
      firstDone = doneCyc;
      applyStimulus(1'b0, 16'h0044, 3'd2, 32'h0, 32'h12345678, 0, 1'b0);
      checkOutput("b2b_gap", acceptCyc - firstDone, 0);

      applyStimulus(1'b0, 16'h0048, 3'd2, 32'h0, 32'h0BAD0BAD, 1, 1'b1);
      firstDone = doneCyc;
      applyStimulus(1'b1, 16'h004C, 3'd1, 32'h0000BEEF, 32'h0, 0, 1'b0);
      checkOutput("b2b_after_err_gap", acceptCyc - firstDone, 0);

      // BUSY and IDLE transfer types must not start anything
      HSEL = 1'b1;
      for (int i = 0; i < 4; i++) begin
         HTRANS = (i < 2) ? 2'b01 : 2'b00;
         @(negedge HCLK);
         checkOutput("notrans_hreadyout", HREADYOUT, 1);
         checkOutput("notrans_psel", PSEL, 0);
         #1;
      end

      HTRANS     = 2'b10;
      HWRITE     = 1'b1;
      blockReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checkOutput("hready_low_psel", PSEL, 0);
         checkOutput("hready_low_hreadyout", HREADYOUT, 1);
      end
      HSEL       = 1'b0;
      HTRANS     = 2'b00;
      blockReady = 1'b0;
      idleCycles(1);

      // Reset asserted in the middle of a stalled ACCESS
      driveAddr(1'b0, 16'h0300, 3'd2, 32'h0, 32'h55AA55AA, 5, 1'b0);
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!PENABLE && n < 20);
      if (!PENABLE)
         checkOutput("access_timeout", 0, 1);
      #2 HRESETn = 1'b0;
      #1;
      checkOutput("abort_psel", PSEL, 0);
      checkOutput("abort_penable", PENABLE, 0);
      checkOutput("abort_hreadyout", HREADYOUT, 1);
      checkOutput("abort_hresp", HRESP, 0);
      checkOutput("abort_paddr", PADDR, 0);
      checkOutput("abort_hrdata", HRDATA, 0);
      ahbQ.delete();
      apbQ.delete();
      modelHrdata = 32'h0;
      @(negedge HCLK);
      #2 HRESETn = 1'b1;
      idleCycles(1);
      checkOutput("post_abort_psel", PSEL, 0);
      applyStimulus(1'b0, 16'h0304, 3'd2, 32'h0, 32'h0BADF00D, 1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         wr = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 3));
         applyStimulus(wr, AW'($urandom), sz, $urandom, $urandom,
                       int'($urandom_range(0, 2)), 1'b0);
      end
      idleCycles(2);
      checkOutput("ahb_queue_drained", ahbQ.size(), 0);
      checkOutput("apb_queue_drained", apbQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
